// File: rtl/ssit.sv
// Store Set ID Table: maps four fetched memory slots to store set IDs, trains
// from load/store order violations with store-set merging, and ages out by sweep.
module ssit #(
  parameter int INDEX_W      = 8,
  parameter int SSID_W       = 7,
  parameter int CLEAR_PERIOD = 65536
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] pc0_in,
  input  logic [INDEX_W-1:0] pc1_in,
  input  logic [INDEX_W-1:0] pc2_in,
  input  logic [INDEX_W-1:0] pc3_in,
  input  logic               valid0_in,
  input  logic               valid1_in,
  input  logic               valid2_in,
  input  logic               valid3_in,
  output logic [SSID_W-1:0]  ssid0_out,
  output logic [SSID_W-1:0]  ssid1_out,
  output logic [SSID_W-1:0]  ssid2_out,
  output logic [SSID_W-1:0]  ssid3_out,
  output logic               valid0_out,
  output logic               valid1_out,
  output logic               valid2_out,
  output logic               valid3_out,
  input  logic               viol_valid_in,
  output logic               viol_ready_out,
  input  logic [INDEX_W-1:0] viol_load_idx_in,
  input  logic [INDEX_W-1:0] viol_store_idx_in,
  output logic               clear_active_out
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int CNT_W = $clog2(CLEAR_PERIOD);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLEAR_PERIOD - 1);
  localparam logic [INDEX_W-1:0] PTR_LAST = INDEX_W'(DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  function automatic logic [SSID_W-1:0] ssid_min(input logic [SSID_W-1:0] a,
                                                 input logic [SSID_W-1:0] b);
    ssid_min = (a < b) ? a : b;
  endfunction

  logic [DEPTH-1:0]   valid_q;
  logic [SSID_W-1:0]  ssid_q [DEPTH];

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ld_q, ld_d;
  logic [INDEX_W-1:0] st_q, st_d;
  logic [SSID_W-1:0]  alloc_q, alloc_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ready_s;
  logic               wr_en_s;
  logic [SSID_W-1:0]  wr_ssid_s;
  logic               clr_en_s;
  logic               ld_v_s;
  logic               st_v_s;
  logic [SSID_W-1:0]  ld_ssid_s;
  logic [SSID_W-1:0]  st_ssid_s;

  // Lookup ports read registered table state directly; no write bypass.
  assign ssid0_out  = ssid_q[pc0_in];
  assign ssid1_out  = ssid_q[pc1_in];
  assign ssid2_out  = ssid_q[pc2_in];
  assign ssid3_out  = ssid_q[pc3_in];
  assign valid0_out = valid_q[pc0_in] & valid0_in;
  assign valid1_out = valid_q[pc1_in] & valid1_in;
  assign valid2_out = valid_q[pc2_in] & valid2_in;
  assign valid3_out = valid_q[pc3_in] & valid3_in;

  assign ld_v_s    = valid_q[ld_q];
  assign st_v_s    = valid_q[st_q];
  assign ld_ssid_s = ssid_q[ld_q];
  assign st_ssid_s = ssid_q[st_q];

  assign viol_ready_out   = ready_s;
  assign clear_active_out = (state_q == CLEAR);

  // Next-state logic: violation capture, merge decision, sweep pointer and timer.
  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    st_d      = st_q;
    alloc_d   = alloc_q;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    wr_en_s   = 1'b0;
    wr_ssid_s = alloc_q;
    clr_en_s  = 1'b0;
    ready_s   = (state_q == IDLE) && !pend_q;

    case (state_q)
      IDLE: begin
        if (viol_valid_in && ready_s) begin
          state_d = TRAIN;
          ld_d    = viol_load_idx_in;
          st_d    = viol_store_idx_in;
        end else if (pend_q) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      TRAIN: begin
        // Both entries always end up with the merged SSID; rewriting the
        // already-holding entry is harmless and covers ld_q == st_q.
        wr_en_s = 1'b1;
        case ({ld_v_s, st_v_s})
          2'b00: begin
            wr_ssid_s = alloc_q;
            alloc_d   = alloc_q + SSID_W'(1);
          end
          2'b10:   wr_ssid_s = ld_ssid_s;
          2'b01:   wr_ssid_s = st_ssid_s;
          2'b11:   wr_ssid_s = ssid_min(ld_ssid_s, st_ssid_s);
          default: wr_ssid_s = alloc_q;
        endcase
        if (pend_q) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_en_s = 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          pend_d  = 1'b0;
        end else begin
          ptr_d   = ptr_q + INDEX_W'(4);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == CLEAR) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      pend_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ld_q    <= '0;
      st_q    <= '0;
      alloc_q <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      alloc_q <= alloc_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry valid bits: sweep invalidates a group of four, training sets both targets.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (clr_en_s) begin
        for (int k = 0; k < 4; k++) begin
          valid_q[ptr_q + INDEX_W'(k)] <= 1'b0;
        end
      end
      if (wr_en_s) begin
        valid_q[ld_q] <= 1'b1;
        valid_q[st_q] <= 1'b1;
      end
    end
  end

  // SSID fields carry no reset; a reset edge still suppresses the training write.
  always_ff @(posedge clock) begin
    if (reset_n && wr_en_s) begin
      ssid_q[ld_q] <= wr_ssid_s;
      ssid_q[st_q] <= wr_ssid_s;
    end
  end

endmodule

// File: tb/tb_ssit.sv
// Bench for ssit: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the table, allocator and clear schedule.
module tb_ssit;

  localparam int IW     = 4;
  localparam int SW     = 7;
  localparam int PERIOD = 64;
  localparam int DEPTH  = 1 << IW;

  logic clock;
  logic reset_n;
  logic [3:0][IW-1:0] pc;
  logic [3:0]         vin;
  logic [3:0][SW-1:0] so;
  logic [3:0]         vo;
  logic viol_valid;
  logic viol_ready;
  logic [IW-1:0] viol_ld;
  logic [IW-1:0] viol_st;
  logic clear_active;

  int n_cmp;
  int n_bad;

  ssit #(.INDEX_W(IW), .SSID_W(SW), .CLEAR_PERIOD(PERIOD)) dut (
    .clock(clock), .reset_n(reset_n),
    .pc0_in(pc[0]), .pc1_in(pc[1]), .pc2_in(pc[2]), .pc3_in(pc[3]),
    .valid0_in(vin[0]), .valid1_in(vin[1]), .valid2_in(vin[2]), .valid3_in(vin[3]),
    .ssid0_out(so[0]), .ssid1_out(so[1]), .ssid2_out(so[2]), .ssid3_out(so[3]),
    .valid0_out(vo[0]), .valid1_out(vo[1]), .valid2_out(vo[2]), .valid3_out(vo[3]),
    .viol_valid_in(viol_valid), .viol_ready_out(viol_ready),
    .viol_load_idx_in(viol_ld), .viol_store_idx_in(viol_st),
    .clear_active_out(clear_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: table contents, allocation count, and the clear schedule
  // expressed as "cycles until sweep" and "sweep groups remaining".
  bit m_valid [DEPTH];
  int m_ssid  [DEPTH];
  int m_alloc, m_allocs, m_timer, m_sweep, m_ld, m_st, m_v, m_base;
  bit m_pend, m_train, m_counting, m_old_pend;

  function automatic bit m_ready();
    return !m_train && (m_sweep == 0) && !m_pend;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_alloc = 0; m_allocs = 0; m_timer = 0; m_sweep = 0;
      m_pend = 1'b0; m_train = 1'b0;
    end else begin
      m_counting = (m_sweep == 0);
      m_old_pend = m_pend;
      if (m_train) begin
        if (!m_valid[m_ld] && !m_valid[m_st]) begin
          m_v = m_alloc;
          m_alloc = (m_alloc + 1) % (1 << SW);
          m_allocs++;
        end else if (m_valid[m_ld] && m_valid[m_st]) begin
          m_v = (m_ssid[m_ld] < m_ssid[m_st]) ? m_ssid[m_ld] : m_ssid[m_st];
        end else begin
          m_v = m_valid[m_ld] ? m_ssid[m_ld] : m_ssid[m_st];
        end
        m_valid[m_ld] = 1'b1; m_ssid[m_ld] = m_v;
        m_valid[m_st] = 1'b1; m_ssid[m_st] = m_v;
        m_train = 1'b0;
        if (m_old_pend) m_sweep = DEPTH / 4;
      end else if (m_sweep > 0) begin
        m_base = DEPTH - 4 * m_sweep;
        for (int k = 0; k < 4; k++) m_valid[m_base + k] = 1'b0;
        m_sweep--;
        if (m_sweep == 0) m_pend = 1'b0;
      end else if (viol_valid && !m_old_pend) begin
        m_ld = int'(viol_ld); m_st = int'(viol_st); m_train = 1'b1;
      end else if (m_old_pend) begin
        m_sweep = DEPTH / 4;
      end
      if (m_counting) begin
        if (m_timer == PERIOD - 1) begin
          m_timer = 0; m_pend = 1'b1;
        end else begin
          m_timer++;
        end
      end else begin
        m_timer = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; viol_valid = 1'b0; vin = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Presents one violation and returns at the negedge where the update is visible.
  task automatic send_viol(input int ld, input int st);
    int guard;
    viol_ld = IW'(ld); viol_st = IW'(st); viol_valid = 1'b1;
    guard = 0;
    while (!viol_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL send_viol timeout: ready stayed %0d, required 1", viol_ready);
    end
    @(negedge clock);
    viol_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    pc[0] = IW'(5); vin[0] = 1'b1;
    #1;
    n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %0b need 0", vo[0]); end
    n_cmp++; if (viol_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b need 1", viol_ready); end
    n_cmp++; if (clear_active !== 1'b0) begin n_bad++; $display("FAIL reset_clear: got %0b need 0", clear_active); end
  endtask

  task automatic test_fresh();
    do_reset();
    pc[0] = IW'(1); pc[1] = IW'(2); vin = 4'b0011;
    viol_ld = IW'(1); viol_st = IW'(2); viol_valid = 1'b1;
    @(negedge clock);
    viol_valid = 1'b0;
    #1;
    n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL fresh_no_bypass: got %0b need 0", vo[0]); end
    n_cmp++; if (viol_ready !== 1'b0) begin n_bad++; $display("FAIL fresh_train_ready: got %0b need 0", viol_ready); end
    @(negedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (vo[s] !== 1'b1 || so[s] !== 7'd0) begin
        n_bad++; $display("FAIL fresh_first slot%0d: got v=%0b ssid=%0d need v=1 ssid=0", s, vo[s], so[s]);
      end
    end
    send_viol(3, 4);
    pc[0] = IW'(3); pc[1] = IW'(4);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (vo[s] !== 1'b1 || so[s] !== 7'd1) begin
        n_bad++; $display("FAIL fresh_second slot%0d: got v=%0b ssid=%0d need v=1 ssid=1", s, vo[s], so[s]);
      end
    end
  endtask

  task automatic test_merge();
    do_reset();
    send_viol(5, 6); send_viol(7, 8); send_viol(9, 10); send_viol(1, 11);
    // Entry 1 holds SSID 3, entry 8 holds SSID 1.
    send_viol(1, 8);
    send_viol(9, 12);
    send_viol(13, 5);
    send_viol(14, 14);
    pc[0] = IW'(1); pc[1] = IW'(8); pc[2] = IW'(12); pc[3] = IW'(13); vin = 4'b1111;
    #1;
    n_cmp++; if (so[0] !== 7'd1 || so[1] !== 7'd1) begin
      n_bad++; $display("FAIL merge_min: got %0d/%0d need 1/1", so[0], so[1]);
    end
    n_cmp++; if (vo[2] !== 1'b1 || so[2] !== 7'd2) begin
      n_bad++; $display("FAIL merge_load_to_store: got v=%0b ssid=%0d need v=1 ssid=2", vo[2], so[2]);
    end
    n_cmp++; if (vo[3] !== 1'b1 || so[3] !== 7'd0) begin
      n_bad++; $display("FAIL merge_store_to_load: got v=%0b ssid=%0d need v=1 ssid=0", vo[3], so[3]);
    end
    pc[0] = IW'(14);
    #1;
    n_cmp++; if (vo[0] !== 1'b1 || so[0] !== 7'd4) begin
      n_bad++; $display("FAIL merge_same_index: got v=%0b ssid=%0d need v=1 ssid=4", vo[0], so[0]);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    do_reset();
    acc = 0;
    viol_valid = 1'b1; viol_ld = IW'(1); viol_st = IW'(2);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin viol_ld = IW'(3); viol_st = IW'(4); end
      #1;
      n_cmp++; if (viol_ready !== ((c % 2) == 0)) begin
        n_bad++; $display("FAIL b2b_ready cycle%0d: got %0b need %0b", c, viol_ready, (c % 2) == 0);
      end
      if (viol_ready) acc++;
      @(negedge clock);
    end
    viol_valid = 1'b0;
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL b2b_accepted: got %0d need 2", acc); end
    pc[0] = IW'(1); pc[1] = IW'(2); pc[2] = IW'(3); pc[3] = IW'(4); vin = 4'b1111;
    #1;
    n_cmp++; if (vo !== 4'b1111 || so[0] !== 7'd0 || so[1] !== 7'd0 || so[2] !== 7'd1 || so[3] !== 7'd1) begin
      n_bad++; $display("FAIL b2b_table: got v=%b ssid=%0d,%0d,%0d,%0d need v=1111 ssid=0,0,1,1",
                        vo, so[0], so[1], so[2], so[3]);
    end
  endtask

  task automatic test_periodic_clear();
    int guard, cyc;
    do_reset();
    send_viol(1, 2); send_viol(3, 4); send_viol(5, 5);
    guard = 0;
    while (!clear_active && guard < 200) begin @(negedge clock); guard++; end
    n_cmp++; if (guard >= 200) begin n_bad++; $display("FAIL clear_start: clear_active never rose, need 1"); end
    viol_ld = IW'(7); viol_st = IW'(8); viol_valid = 1'b1;
    cyc = 0;
    while (clear_active && cyc < 20) begin
      n_cmp++; if (viol_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready: got %0b need 0", viol_ready); end
      cyc++;
      @(negedge clock);
    end
    n_cmp++; if (cyc != DEPTH / 4) begin n_bad++; $display("FAIL clear_length: got %0d need %0d", cyc, DEPTH / 4); end
    n_cmp++; if (viol_ready !== 1'b1) begin n_bad++; $display("FAIL clear_first_idle_ready: got %0b need 1", viol_ready); end
    @(negedge clock);
    viol_valid = 1'b0;
    vin = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 4; s++) pc[s] = IW'(4 * r + s);
      #1;
      n_cmp++; if (vo !== 4'b0000) begin n_bad++; $display("FAIL clear_swept group%0d: got %b need 0000", r, vo); end
    end
    @(negedge clock);
    pc[0] = IW'(7); pc[1] = IW'(8);
    #1;
    n_cmp++; if (vo[1:0] !== 2'b11 || so[0] !== 7'd3 || so[1] !== 7'd3) begin
      n_bad++; $display("FAIL clear_post_viol: got v=%b ssid=%0d/%0d need v=11 ssid=3/3", vo[1:0], so[0], so[1]);
    end
  endtask

  task automatic test_wrap_and_abort();
    int guard, idx, last;
    do_reset();
    guard = 0; last = 0;
    while (m_allocs < 129 && guard < 6000) begin
      idx = -1;
      for (int i = 0; i < DEPTH; i++) if (idx < 0 && !m_valid[i]) idx = i;
      if (idx < 0) begin
        @(negedge clock); guard++;
      end else begin
        send_viol(idx, idx); guard += 2;
        pc[0] = IW'(idx); vin[0] = 1'b1;
        #1;
        if (m_allocs == 128) begin
          n_cmp++; if (vo[0] !== 1'b1 || so[0] !== 7'd127) begin
            n_bad++; $display("FAIL wrap_128th: got v=%0b ssid=%0d need v=1 ssid=127", vo[0], so[0]);
          end
        end else if (m_allocs == 129) begin
          last = 1;
          n_cmp++; if (vo[0] !== 1'b1 || so[0] !== 7'd0) begin
            n_bad++; $display("FAIL wrap_129th: got v=%0b ssid=%0d need v=1 ssid=0", vo[0], so[0]);
          end
        end
      end
    end
    n_cmp++; if (last != 1) begin n_bad++; $display("FAIL wrap_budget: reached %0d allocations, need 129", m_allocs); end
    do_reset();
    viol_ld = IW'(5); viol_st = IW'(6); viol_valid = 1'b1;
    @(negedge clock);
    viol_valid = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    pc[0] = IW'(5); pc[1] = IW'(6); vin = 4'b0011;
    #1;
    n_cmp++; if (vo[1:0] !== 2'b00 || viol_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_train: got v=%b ready=%0b need v=00 ready=1", vo[1:0], viol_ready);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int s = 0; s < 4; s++) begin
        pc[s] = IW'($urandom_range(0, DEPTH - 1));
        vin[s] = 1'($urandom_range(0, 3) != 0);
      end
      viol_valid = 1'($urandom_range(0, 1));
      viol_ld = IW'($urandom_range(0, DEPTH - 1));
      viol_st = IW'($urandom_range(0, DEPTH - 1));
      #1;
      n_cmp++; if (viol_ready !== m_ready()) begin
        n_bad++; $display("FAIL rand_ready cyc%0d: got %0b need %0b", c, viol_ready, m_ready());
      end
      n_cmp++; if (clear_active !== (m_sweep > 0)) begin
        n_bad++; $display("FAIL rand_clear cyc%0d: got %0b need %0b", c, clear_active, m_sweep > 0);
      end
      for (int s = 0; s < 4; s++) begin
        n_cmp++; if (vo[s] !== (m_valid[pc[s]] & vin[s])) begin
          n_bad++; $display("FAIL rand_valid cyc%0d slot%0d: got %0b need %0b", c, s, vo[s], m_valid[pc[s]] & vin[s]);
        end
        if (m_valid[pc[s]] && vin[s]) begin
          n_cmp++; if (so[s] !== SW'(m_ssid[pc[s]])) begin
            n_bad++; $display("FAIL rand_ssid cyc%0d slot%0d: got %0d need %0d", c, s, so[s], m_ssid[pc[s]]);
          end
        end
      end
      @(negedge clock);
    end
    viol_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; viol_valid = 1'b0; viol_ld = '0; viol_st = '0;
    pc = '0; vin = '0;
    test_reset();
    test_fresh();
    test_merge();
    test_back_to_back();
    test_periodic_clear();
    test_wrap_and_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssit.md
# ssit

Store Set ID Table: the PC-indexed predictor stage directly upstream of the last fetched store table in rename. Each cycle it maps up to four fetched memory instructions to a 7-bit store set ID (SSID) plus valid bit, which drive the LFST `ssidN_in`/`validN_in` ports. The retire/LSQ logic reports memory-order violations, and the table trains from them with store-set merging. A periodic sweep clears the table so stale dependences age out.

## Interface
- `INDEX_W`, default 8: table index width; the table has 2^INDEX_W entries, with INDEX_W ≥ 2.
- `SSID_W`, default 7: SSID width; must equal the LFST SSID width.
- `CLEAR_PERIOD`, default 65536: cycles between periodic clears; must be ≥ 2.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `pc0_in`..`pc3_in`  in  INDEX_W: hashed PC index of bundle slots 0–3.
- `valid0_in`..`valid3_in`  in  1: slot holds a load or store.
- `ssid0_out`..`ssid3_out`  out  SSID_W: SSID stored at the slot's entry.
- `valid0_out`..`valid3_out`  out  1: entry valid AND the slot's `validN_in`.
- `viol_valid_in`  in  1: violation report present.
- `viol_ready_out`  out  1: block accepts a violation this cycle.
- `viol_load_idx_in`  in  INDEX_W: index of the violating load.
- `viol_store_idx_in`  in  INDEX_W: index of the store the load bypassed.
- `clear_active_out`  out  1: periodic sweep in progress.

## Operation
- **Storage.** Per entry: one valid bit and an SSID_W-bit SSID. There is no write bypass. The lookup ports read current register state combinationally.
- **Allocator.** An SSID_W-bit counter `alloc`. It resets to 0, increments by 1 on each allocation, and wraps from 2^SSID_W−1 to 0.
- **FSM states:** IDLE, TRAIN, CLEAR.
  - `viol_ready_out` = (state==IDLE && !clear_pending).
  - IDLE → TRAIN: on `viol_valid_in && viol_ready_out`. Load and store indices are captured into `ld_q`/`st_q`.
  - TRAIN (one cycle): read both entries at `ld_q`/`st_q` and apply the merge rule. The write takes effect at the edge that ends TRAIN. Next state is CLEAR if `clear_pending`, else IDLE.
  - IDLE → CLEAR: when `clear_pending` is set and no violation is accepted.
  - CLEAR: pointer `clr_ptr` starts at 0. Each edge invalidates entries clr_ptr..clr_ptr+3, then clr_ptr += 4. After the edge that clears the last group (2^INDEX_W/4 cycles), go to IDLE, zero `clr_ptr`, and clear `clear_pending`. SSID fields are not cleared.
- **Merge rule** (L/S = load/store entry valid; Ls/Ss = their SSIDs):
  - !L && !S: both entries get SSID=`alloc` with valid=1; `alloc` increments.
  - L && !S: the store entry gets Ls.
  - !L && S: the load entry gets Ss.
  - L && S: both entries get min(Ls, Ss); this is a no-op if equal.
  - `ld_q`==`st_q`: the single entry is written once with the rule result.
- **Clear timer.** `clr_cnt` counts every cycle the state is not CLEAR. When it reaches CLEAR_PERIOD−1 it sets `clear_pending` and returns to 0. It stays 0 during CLEAR. `clear_pending` set while in TRAIN defers CLEAR until TRAIN ends.
- Lookups stay live in every state. During CLEAR they may return a partially swept table.

## Timing
- **Reset** (`reset_n`=0 at an edge): all valid bits 0, `alloc`=0, `clr_cnt`=0, `clr_ptr`=0, `clear_pending`=0, state IDLE.
- **Outputs after reset:** `viol_ready_out`=1, `clear_active_out`=0, all `validN_out`=0. `ssidN_out` is unspecified until first written.
- **Reset mid-TRAIN or mid-CLEAR:** the operation is aborted with no partial write at that edge, and everything returns to reset values.
- **Violation latency.** Accepted at edge E. State is TRAIN in the cycle after E. The table update is visible on the lookup outputs in the cycle after E+1.
- **Throughput:** at most one violation per 2 cycles. `viol_ready_out` is low during TRAIN and CLEAR and while `clear_pending` is set.
- `clear_active_out` = (state==CLEAR).
- **Lookup path** (`validN_out`/`ssidN_out`) is combinational from `pcN_in`, `validN_in` and registered state. It has zero latency.

## Test plan
- **Reset then lookup:** apply reset, then lookup of `pc0_in`=5 with `valid0_in`=1 → `valid0_out`=0 and `viol_ready_out`=1.
- **Fresh violation:** load 0x10, store 0x20, both invalid. Two cycles later, lookups of 0x10 and 0x20 both return SSID 0, valid 1, and `alloc`=1. A second fresh pair (0x30/0x40) gets SSID 1.
- **Merge:** load 0x10=SSID 3, store 0x20=SSID 1 → both return 1. A load valid / store invalid case copies the load SSID to the store.
- **Back-to-back violations:** `viol_valid_in` held high for 4 cycles → exactly 2 accepted, with ready toggling 1,0,1,0.
- **Periodic clear:** CLEAR_PERIOD=64, INDEX_W=4, with entries populated. After 63 non-CLEAR cycles, CLEAR lasts 4 cycles with `clear_active_out`=1 and ready=0, and every lookup valid=0 afterwards. A violation asserted during CLEAR is accepted on the first IDLE cycle.
- **Counter wrap and reset abort:** force 128 fresh allocations → the 129th gets SSID 0. Asserting `reset_n`=0 during TRAIN leaves the targeted entries invalid.
